mvm_requant_out: RTL
====================

Name: mvm_requant_out

Overview:
- Downstream stage of the 3x3 matrix-vector multiplier; consumes its 16-bit signed y[] output stream over a valid/ready handshake.
- Rounds, arithmetic-shifts and saturates each element to 8-bit signed, so results can feed the next layer's 8-bit data_in.
- Buffers results in a small FIFO and tags the last element of each SIZE-element vector.

Parameters:
- SIZE, 3, elements per output vector; drives the m_last counter.
- SHIFT, 4, right-shift amount, range 0..15.
- DEPTH, 4, FIFO entries; must be a power of 2 and >= 2.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- s_valid  input  1  upstream data_in is valid.
- s_ready  output  1  block can accept data_in this cycle.
- data_in  input  16  signed y element from the multiplier.
- m_valid  output  1  data_out is valid.
- m_ready  input  1  downstream accepts data_out this cycle.
- data_out  output  8  signed requantized element.
- m_last  output  1  data_out is element SIZE-1 of its vector; qualified by m_valid.

Behaviour:
- Reset: clears FIFO pointers, occupancy count and element counter. After reset, m_valid=0, m_last=0, s_ready=1 and data_out=0 (storage contents are don't-care). Reset overrides any handshake in the same cycle, including mid-vector or with a full FIFO.
- Input handshake:
  - s_ready = not full, decoded from registers only; no combinational path from m_ready.
  - Push occurs when s_valid && s_ready.
  - When the FIFO is full, no push occurs even if a pop happens in the same cycle.
  - data_in is ignored (may be X) when s_valid=0.
- Arithmetic (per accepted element, combinational before the FIFO write):
  - Sign-extend data_in to 17 bits.
  - If SHIFT>0, add 2^(SHIFT-1) (round half up).
  - Arithmetic right shift by SHIFT.
  - Saturate to [-128, 127].
  - The 17-bit intermediate must not overflow for any 16-bit input.
- FIFO:
  - DEPTH entries of 8 bits, with read/write pointers and a separate occupancy count.
  - Push and pop in the same cycle (not full, not empty) leaves the count unchanged.
  - Pointers wrap modulo DEPTH.
- Output:
  - m_valid = not empty. data_out = FIFO head, stable while m_valid && !m_ready.
  - Pop occurs when m_valid && m_ready.
  - Latency: an element accepted at edge N is visible on data_out with m_valid=1 after edge N (one cycle), if the FIFO was empty.
- Element counter:
  - Range 0..SIZE-1; increments on each pop and wraps to 0 after SIZE-1.
  - m_last = m_valid && (counter == SIZE-1).
  - The counter does not change while the output is stalled.
- Empty FIFO: m_valid=0 and m_last=0; data_out holds its last value.
- No FSM beyond FIFO and counter state; no input is dropped or duplicated under any handshake pattern.

Optional Feature:
- Macro: MVM_REQUANT_RELU_EN.
- Defined: after sign extension, negative inputs are forced to 0 before rounding and shift, so the output range is [0, 127].
- Not defined: signed saturation as above, output range [-128, 127].
- No port or latency change either way.

Test Plan:
- Arithmetic, SHIFT=4, m_ready held 1; inputs 0x0120, 0x0007, 0x0008, 0x7FFF, 0x8000, 0xFFE8:
  - Macro off -> 0x12, 0x00, 0x01, 0x7F, 0x80, 0xFF.
  - Macro on -> 0x12, 0x00, 0x01, 0x7F, 0x00, 0x00.
- Backpressure, m_ready=0, s_valid=1 with 5 values 1..5 (each <<4):
  - First 4 accepted; s_ready=0 after 4th edge; 5th held.
  - Raise m_ready -> outputs 1,2,3,4,5 in order, 5th accepted one cycle after first pop.
- m_last, SIZE=3, 9 elements with random s_valid/m_ready -> m_last=1 exactly on output handshakes 3, 6, 9; never while m_valid=0.
- Latency, empty FIFO, single push at edge N -> m_valid=1 after edge N; after pop at N+1 with no new push, m_valid=0.
- Reset mid-operation: 2 elements queued, counter at 1, assert reset one cycle -> m_valid=0, s_ready=1, counter=0; next three outputs give m_last only on the third.
- Random stress, 5 vectors x 3 elements, random s_valid/m_ready, X on data_in when s_valid=0 -> output stream equals the reference model element-for-element; no X on data_out while m_valid=1.

Source files
------------

// File: rtl/mvm_requant_out_if.sv
// Stream bundle around mvm_requant_out: 16-bit y elements in, 8-bit requantized elements out.
// The master modport is the environment side; the slave modport is the block itself.
interface mvm_requant_out_if;
  logic        s_valid;
  logic        s_ready;
  logic [15:0] data_in;
  logic        m_valid;
  logic        m_ready;
  logic [7:0]  data_out;
  logic        m_last;

  modport master (
    output s_valid, data_in, m_ready,
    input  s_ready, m_valid, data_out, m_last
  );

  modport slave (
    input  s_valid, data_in, m_ready,
    output s_ready, m_valid, data_out, m_last
  );
endinterface

// File: rtl/mvm_requant_out.sv
// Requantizes 16-bit signed y elements to 8-bit (round, shift, saturate) and queues them with a per-vector last tag.
// Define MVM_REQUANT_RELU_EN to clamp negative inputs to zero before rounding (output range [0, 127]).
module mvm_requant_out #(
  parameter int SIZE  = 3,
  parameter int SHIFT = 4,
  parameter int DEPTH = 4
) (
  input  logic               clk,
  input  logic               reset,
  mvm_requant_out_if.slave   bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam logic signed [16:0] ROUND =
    (SHIFT > 0) ? (17'sd1 <<< ((SHIFT > 0) ? SHIFT - 1 : 0)) : 17'sd0;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic [CW-1:0] elem_cnt;
  logic [7:0]    last_q;
  logic          full, empty, push, pop;

  logic signed [16:0] ext, rnd, shr;
  logic [7:0]         quant;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    ext = {bus.data_in[15], bus.data_in};
`ifdef MVM_REQUANT_RELU_EN
    if (ext < 17'sd0) ext = 17'sd0;
`endif
    // 17 bits hold 32767 + 2^14 without overflow, so rounding never wraps.
    rnd = ext + ROUND;
    shr = rnd >>> SHIFT;
    if (shr > 17'sd127)       quant = 8'h7F;
    else if (shr < -17'sd128) quant = 8'h80;
    else                      quant = shr[7:0];
  end

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign push  = bus.s_valid && !full;
  assign pop   = !empty && bus.m_ready;

  assign bus.s_ready  = !full;
  assign bus.m_valid  = !empty;
  assign bus.m_last   = !empty && (elem_cnt == CW'(SIZE - 1));
  // When empty, show the most recently popped element rather than stale storage.
  assign bus.data_out = empty ? last_q : mem[rd_ptr];

  // NOTE: storage carries no reset; pointers and count alone define which entries are meaningful.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= quant;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      elem_cnt <= '0;
      last_q   <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr   <= rd_ptr + 1'b1;
        last_q   <= mem[rd_ptr];
        elem_cnt <= (elem_cnt == CW'(SIZE - 1)) ? '0 : elem_cnt + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule
